// File: rtl/inst_fetch.sv
// Instruction fetch stage: a three-state request/hold FSM that fetches one word at pc,
// holds it for decode, and redirects pc on jump or taken branch when decode consumes it.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic        branch_taken,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_t;

  state_t      state;
  logic        consume;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign inst_addr = pc;
  assign op        = instr[31:26];
  assign pc_plus4  = pc + 32'd4;
  assign consume   = (state == S_HOLD) && instr_valid && instr_ready;

  always_comb begin
    branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    next_pc    = pc_plus4;
    // Jump has priority over a taken branch.
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      inst_req    <= 1'b0;
      retire_cnt  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          inst_req <= 1'b1;
        end
        S_REQ: begin
          if (inst_ack) begin
            instr       <= inst_rdata;
            instr_valid <= 1'b1;
            inst_req    <= 1'b0;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (consume) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            retire_cnt  <= retire_cnt + 32'd1;
            inst_req    <= 1'b1;
            state       <= S_REQ;
          end
        end
        default: begin
          state    <= S_IDLE;
          inst_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: sequential fetch, jump/branch redirects, stalls,
// address wrap and asynchronous reset in the middle of a request.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_ready;
  logic        jump;
  logic        branch_taken;
  logic [31:0] retire_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_retire = 0;

  always #5 clk = ~clk;

  inst_fetch #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_ack    (inst_ack),
    .inst_rdata  (inst_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .op          (op),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_ready (instr_ready),
    .jump        (jump),
    .branch_taken(branch_taken),
    .retire_cnt  (retire_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Serve one fetch at exp_addr, then consume it with the given redirect flags.
  // Called and returns at a falling edge.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] rdata,
                       input int ack_wait, input int rdy_wait,
                       input logic jmp, input logic br);
    int n = 0;
    while (!inst_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_seen", {31'h0, inst_req}, 32'h1);
    check_eq("addr", inst_addr, exp_addr);
    repeat (ack_wait) begin
      instr_ready = 1'b1;
      @(negedge clk);
      check_eq("req_stall", {31'h0, inst_req}, 32'h1);
      check_eq("addr_stall", inst_addr, exp_addr);
      check_eq("retire_req_stall", retire_cnt, exp_retire);
    end
    instr_ready = 1'b0;
    inst_ack    = 1'b1;
    inst_rdata  = rdata;
    @(negedge clk);
    inst_ack   = 1'b0;
    inst_rdata = 32'hDEAD_BEEF;
    check_eq("valid", {31'h0, instr_valid}, 32'h1);
    check_eq("instr", instr, rdata);
    check_eq("op", {26'h0, op}, {26'h0, rdata[31:26]});
    check_eq("pc", pc, exp_addr);
    check_eq("pc_plus4", pc_plus4, exp_addr + 32'd4);
    check_eq("req_hold", {31'h0, inst_req}, 32'h0);
    repeat (rdy_wait) begin
      inst_ack = 1'b1;
      jump     = 1'b1;
      @(negedge clk);
      check_eq("valid_stall", {31'h0, instr_valid}, 32'h1);
      check_eq("instr_stall", instr, rdata);
      check_eq("pc_stall", pc, exp_addr);
      check_eq("req_hold_stall", {31'h0, inst_req}, 32'h0);
    end
    inst_ack     = 1'b0;
    instr_ready  = 1'b1;
    jump         = jmp;
    branch_taken = br;
    @(negedge clk);
    instr_ready  = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    exp_retire++;
    check_eq("retire", retire_cnt, exp_retire);
    check_eq("valid_consumed", {31'h0, instr_valid}, 32'h0);
    check_eq("req_after_consume", {31'h0, inst_req}, 32'h1);
  endtask

  initial begin
    rst          = 1'b1;
    inst_ack     = 1'b0;
    inst_rdata   = 32'h0;
    instr_ready  = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_req", {31'h0, inst_req}, 32'h0);
    check_eq("rst_valid", {31'h0, instr_valid}, 32'h0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_retire", retire_cnt, 32'h0);
    check_eq("rst_op", {26'h0, op}, 32'h0);
    check_eq("rst_pc_plus4", pc_plus4, 32'h4);

    // Release reset with a stray ack during the idle cycle.
    rst        = 1'b0;
    inst_ack   = 1'b1;
    inst_rdata = 32'hFFFF_FFFF;
    check_eq("idle_req", {31'h0, inst_req}, 32'h0);
    @(negedge clk);
    inst_ack = 1'b0;
    check_eq("first_req", {31'h0, inst_req}, 32'h1);
    check_eq("idle_ack_ignored", {31'h0, instr_valid}, 32'h0);

    // Sequential fetch
    fetch(32'h0000_0000, 32'h2000_0000, 0, 0, 1'b0, 1'b0);
    fetch(32'h0000_0004, 32'h2401_0001, 0, 0, 1'b0, 1'b0);
    fetch(32'h0000_0008, 32'h8C22_0004, 0, 0, 1'b0, 1'b0);
    fetch(32'h0000_000C, 32'hAC22_0008, 0, 0, 1'b0, 1'b0);
    check_eq("retire4", retire_cnt, 32'd4);

    // Jumps
    fetch(32'h0000_0010, 32'h0810_0000, 0, 0, 1'b1, 1'b0);
    fetch(32'h0040_0000, 32'h0800_0010, 0, 0, 1'b1, 1'b0);
    fetch(32'h0000_0040, 32'h0800_0040, 0, 0, 1'b1, 1'b0);
    // Branch backwards, then jump beating branch
    fetch(32'h0000_0100, 32'h1000_FFFE, 0, 0, 1'b0, 1'b1);
    fetch(32'h0000_00FC, 32'h1000_0020, 0, 0, 1'b1, 1'b1);
    // Stalled fetch whose branch lands on the top word
    fetch(32'h0000_0080, 32'h1000_FFDE, 3, 5, 1'b0, 1'b1);
    fetch(32'hFFFF_FFFC, 32'h2000_0000, 0, 0, 1'b0, 1'b0);
    fetch(32'h0000_0000, 32'h2000_0000, 0, 0, 1'b0, 1'b0);

    // Asynchronous reset between edges while requesting at pc=4
    check_eq("pre_rst_pc", pc, 32'h4);
    #2 rst = 1'b1;
    #1;
    check_eq("async_req", {31'h0, inst_req}, 32'h0);
    check_eq("async_valid", {31'h0, instr_valid}, 32'h0);
    check_eq("async_pc", pc, 32'h0);
    check_eq("async_retire", retire_cnt, 32'h0);
    exp_retire = 0;
    @(negedge clk);
    rst        = 1'b0;
    inst_ack   = 1'b1;
    inst_rdata = 32'h1234_5678;
    @(negedge clk);
    inst_ack = 1'b0;
    check_eq("stray_ack_valid", {31'h0, instr_valid}, 32'h0);
    check_eq("post_rst_req", {31'h0, inst_req}, 32'h1);
    check_eq("post_rst_addr", inst_addr, 32'h0);
    fetch(32'h0000_0000, 32'h3C01_1000, 0, 0, 1'b0, 1'b0);
    check_eq("post_rst_next", inst_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
